collect_switch_seq: RTL and testbench



---
 rtl/collect_switch_seq.sv | 104 ++++++++++
 tb/tb_collect_switch_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/collect_switch_seq.sv
// 2-to-1 collect switch: merges a high and a low upstream lane onto one
// registered downstream lane with ready/valid handshakes on both sides.
module collect_switch_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data_bus,
  input  logic                    i_ready,
  input  logic                    i_en,
  input  logic [1:0]              i_cmd
);

  typedef enum logic {
    IDLE       = 1'b0,
    DRAIN_HIGH = 1'b1
  } state_t;

  localparam logic [1:0] CMD_LOW   = 2'b01;
  localparam logic [1:0] CMD_HIGH  = 2'b10;
  localparam logic [1:0] CMD_MERGE = 2'b11;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_low;
  logic [DATA_WIDTH-1:0] data_high;

  assign data_low  = i_data_bus[DATA_WIDTH-1:0];
  assign data_high = i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];

  // The output slot can take a new word when it is empty or being consumed now.
  assign slot_free = !o_valid || i_ready;
  assign o_ready   = !rst && i_en && (state == IDLE) && slot_free;
  assign accept    = o_ready && (|i_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= '0;
      o_valid    <= 1'b0;
      o_data_bus <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
            case (i_cmd)
              CMD_LOW: begin
                if (i_valid[0]) begin
                  o_valid    <= 1'b1;
                  o_data_bus <= data_low;
                end
              end
              CMD_HIGH: begin
                if (i_valid[1]) begin
                  o_valid    <= 1'b1;
                  o_data_bus <= data_high;
                end
              end
              CMD_MERGE: begin
                o_valid <= 1'b1;
                if (i_valid == 2'b11) begin
                  o_data_bus <= data_low;
                  hold       <= data_high;
                  state      <= DRAIN_HIGH;
                end else if (i_valid[0]) begin
                  o_data_bus <= data_low;
                end else begin
                  o_data_bus <= data_high;
                end
              end
              default: ;
            endcase
          end else if (i_ready && o_valid) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
          end
        end
        DRAIN_HIGH: begin
          // With the switch disabled the held word waits, but a pending output
          // still finishes its downstream handshake.
          if (i_en && slot_free) begin
            o_valid    <= 1'b1;
            o_data_bus <= hold;
            hold       <= '0;
            state      <= IDLE;
          end else if (i_ready && o_valid) begin
            o_valid    <= 1'b0;
            o_data_bus <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collect_switch_seq.sv
// Directed self-checking bench for collect_switch_seq: inputs change on the
// falling edge, outputs are compared one time unit later.
module tb_collect_switch_seq;

  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_data_bus;
  logic          i_ready;
  logic          i_en;
  logic [1:0]    i_cmd;

  int checks;
  int passed;
  int failed;

  collect_switch_seq #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready),
    .i_en       (i_en),
    .i_cmd      (i_cmd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic en, input logic rdy,
                               input logic [1:0] cmd, input logic [1:0] vld,
                               input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    @(negedge clk);
    rst        = r;
    i_en       = en;
    i_ready    = rdy;
    i_cmd      = cmd;
    i_valid    = vld;
    i_data_bus = {hi, lo};
    #1;
  endtask

  task automatic compareOne(input string tag, input logic [DW-1:0] obs,
                            input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev,
                             input logic [DW-1:0] ed, input logic er);
    compareOne({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, ev});
    compareOne({tag, ".o_data_bus"}, o_data_bus, ed);
    compareOne({tag, ".o_ready"}, {31'd0, o_ready}, {31'd0, er});
  endtask

  // Shorthand for an idle input cycle with the switch enabled.
  task automatic idleStep(input logic rdy);
    applyStimulus(1'b0, 1'b1, rdy, 2'b00, 2'b00, '0, '0);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    failed = 0;
    rst = 1'b1; i_en = 1'b0; i_ready = 1'b0; i_cmd = 2'b00;
    i_valid = 2'b00; i_data_bus = '0;

    // Reset
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, '0, '0);
    checkOutput("reset", 1'b0, 32'h0, 1'b0);

    // Forward low
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 32'hAAAA0000, 32'h0000BBBB);
    checkOutput("fwd_low_in", 1'b0, 32'h0, 1'b1);
    idleStep(1'b1);
    checkOutput("fwd_low_out", 1'b1, 32'h0000BBBB, 1'b1);

    // Merge followed by a back-to-back merge
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'h11111111, 32'h22222222);
    checkOutput("merge_in", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'h33333333, 32'h44444444);
    checkOutput("merge_w0", 1'b1, 32'h22222222, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'h33333333, 32'h44444444);
    checkOutput("merge_w1", 1'b1, 32'h11111111, 1'b1);
    idleStep(1'b1);
    checkOutput("merge2_w0", 1'b1, 32'h44444444, 1'b0);
    idleStep(1'b1);
    checkOutput("merge2_w1", 1'b1, 32'h33333333, 1'b1);
    idleStep(1'b1);
    checkOutput("merge2_done", 1'b0, 32'h0, 1'b1);

    // Merge with downstream stalled for three cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'h11111111, 32'h22222222);
    checkOutput("stall_in", 1'b0, 32'h0, 1'b1);
    idleStep(1'b0);
    checkOutput("stall_c1", 1'b1, 32'h22222222, 1'b0);
    idleStep(1'b0);
    checkOutput("stall_c2", 1'b1, 32'h22222222, 1'b0);
    idleStep(1'b0);
    checkOutput("stall_c3", 1'b1, 32'h22222222, 1'b0);
    idleStep(1'b1);
    checkOutput("stall_release", 1'b1, 32'h22222222, 1'b0);
    idleStep(1'b1);
    checkOutput("stall_high", 1'b1, 32'h11111111, 1'b1);
    idleStep(1'b1);
    checkOutput("stall_done", 1'b0, 32'h0, 1'b1);

    // Mismatched lane and NA command are consumed and dropped
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 2'b01, 32'h12345678, 32'h9ABCDEF0);
    checkOutput("drop_mismatch_in", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 32'h0F0F0F0F, 32'hF0F0F0F0);
    checkOutput("drop_na_in", 1'b0, 32'h0, 1'b1);
    idleStep(1'b1);
    checkOutput("drop_out", 1'b0, 32'h0, 1'b1);

    // Merge with only the high lane valid forwards that word alone
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b10, 32'h00000077, 32'h00000088);
    checkOutput("merge_hi_only_in", 1'b0, 32'h0, 1'b1);
    idleStep(1'b1);
    checkOutput("merge_hi_only_out", 1'b1, 32'h00000077, 1'b1);
    idleStep(1'b1);
    checkOutput("merge_hi_only_done", 1'b0, 32'h0, 1'b1);

    // Forward-high stream, then disable mid-stream
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 32'd1, 32'hFFFF0000);
    checkOutput("stream_1_in", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 32'd2, 32'hFFFF0000);
    checkOutput("stream_out1", 1'b1, 32'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 32'd3, 32'hFFFF0000);
    checkOutput("stream_out2", 1'b1, 32'd2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 32'd4, 32'hFFFF0000);
    checkOutput("stream_out3", 1'b1, 32'd3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 32'd5, 32'hFFFF0000);
    checkOutput("stream_out4_dis", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 32'd5, 32'hFFFF0000);
    checkOutput("stream_dis_hold", 1'b1, 32'd4, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 32'd5, 32'hFFFF0000);
    checkOutput("stream_dis_drained", 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 32'd5, 32'hFFFF0000);
    checkOutput("stream_dis_no_accept", 1'b0, 32'h0, 1'b0);
    idleStep(1'b1);
    checkOutput("stream_reenabled", 1'b0, 32'h0, 1'b1);

    // Reset while the high word is held
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
    checkOutput("rst_merge_in", 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, '0, '0);
    checkOutput("rst_drain_w0", 1'b1, 32'hCAFEF00D, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 2'b00, '0, '0);
    checkOutput("rst_applied", 1'b0, 32'h0, 1'b0);
    idleStep(1'b1);
    checkOutput("rst_after_1", 1'b0, 32'h0, 1'b1);
    idleStep(1'b1);
    checkOutput("rst_after_2", 1'b0, 32'h0, 1'b1);
    idleStep(1'b1);
    checkOutput("rst_after_3", 1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
